// File: rtl/oled_pkg.sv
// oled_pkg: shared types and constants for the OLED command sequencer.
// Holds the FSM state encoding, the i2c-facing register bundle and the
// SSD1306 power-up init table (index 0 is sent first).
package oled_pkg;

    localparam int OLED_INIT_LEN = 25;

    // SSD1306 init: display off, clock, mux, offset, start line, charge pump,
    // addressing, remap, COM config, contrast, precharge, VCOMH, resume, normal, on
    localparam logic [0:OLED_INIT_LEN-1][7:0] OLED_INIT_TBL = {
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_NEXT = 3'd2,
        ACKED     = 3'd3,
        FINISH    = 3'd4
    } oled_state_t;

    // Everything presented to the downstream i2c stage
    typedef struct packed {
        logic [7:0] command;
        logic       enable;
        logic       ack;
    } oled_i2c_t;

endpackage

// File: rtl/oled_init_rom.sv
// oled_init_rom: combinational lookup of the SSD1306 init table.
// Only compiled when OLED_INIT_ROM_EN is defined; indices past the end of
// the table read as 8'h00.
`ifdef OLED_INIT_ROM_EN
module oled_init_rom
    import oled_pkg::*;
#(
    parameter int IDX_W = 5
)(
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       data
);

    // Compare as integers so a narrow index never aliases a higher entry
    always_comb begin
        data = 8'h00;
        for (int i = 0; i < OLED_INIT_LEN; i++) begin
            if (int'(idx) == i) data = OLED_INIT_TBL[i];
        end
    end

endmodule
`endif

// File: rtl/oled_cmd_seq.sv
// oled_cmd_seq: feeds command bytes one at a time to an i2c stage.
// Each transaction optionally starts with the init ROM bytes (macro
// OLED_INIT_ROM_EN), then drains the user byte stream. The i2c stage asks
// for each following byte with a rising edge on next; the transaction ends
// on the first request that finds no byte available.
module oled_cmd_seq
    import oled_pkg::*;
#(
    parameter int INIT_LEN = OLED_INIT_LEN,
    parameter int CNT_W    = 8
)(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             next,
    output logic [7:0]       command,
    output logic             enable,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

    oled_state_t      state, state_nxt;
    oled_i2c_t        i2c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             next_q, next_rise;
    logic             rom_phase, avail;
    logic [7:0]       src_byte;
    logic             tx_start, load_first, load_next, tx_end, ack_drop;

    // A held next level only counts once: act on its rising edge
    assign next_rise = next & ~next_q;

`ifdef OLED_INIT_ROM_EN
    localparam int IDX_W = (INIT_LEN < 1) ? 1 : $clog2(INIT_LEN + 1);

    logic [IDX_W-1:0] rom_idx;
    logic [7:0]       rom_byte;

    oled_init_rom #(.IDX_W(IDX_W)) u_rom (
        .idx  (rom_idx),
        .data (rom_byte)
    );

    assign rom_phase = (int'(rom_idx) < INIT_LEN);
    assign src_byte  = rom_phase ? rom_byte : in_data;

    // ROM index: rewinds on every new transaction, steps per ROM byte sent
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                 rom_idx <= '0;
        else if (tx_start)                            rom_idx <= '0;
        else if ((load_first | load_next) && rom_phase) rom_idx <= rom_idx + 1'b1;
    end
`else
    assign rom_phase = 1'b0;
    assign src_byte  = in_data;
`endif

    // ROM bytes are always on hand; user bytes only when offered
    assign avail = rom_phase | in_valid;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start)     state_nxt = LOAD;
            LOAD:      if (avail)     state_nxt = WAIT_NEXT;
            WAIT_NEXT: if (next_rise) state_nxt = avail ? ACKED : FINISH;
            ACKED:     if (!next)     state_nxt = WAIT_NEXT;
            FINISH:                   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Per-state outputs and datapath strobes
    always_comb begin
        tx_start   = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        tx_end     = 1'b0;
        ack_drop   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                tx_start = start;
            end
            LOAD: begin
                load_first = avail;
                in_ready   = ~rom_phase;
            end
            WAIT_NEXT: begin
                load_next = next_rise & avail;
                tx_end    = next_rise & ~avail;
                in_ready  = next_rise & ~rom_phase;
            end
            ACKED:  ack_drop = ~next;
            FINISH: done     = 1'b1;
            default: busy    = 1'b0;
        endcase
    end

    // Datapath: command holds until the next load, even after enable drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i2c_q  <= '0;
            cnt_q  <= '0;
            next_q <= 1'b0;
        end else begin
            next_q <= next;
            if (tx_start) cnt_q <= '0;
            else if ((load_first | load_next) && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
            if (load_first | load_next) i2c_q.command <= src_byte;
            if (load_first)  i2c_q.enable <= 1'b1;
            else if (tx_end) i2c_q.enable <= 1'b0;
            if (load_next)     i2c_q.ack <= 1'b1;
            else if (ack_drop) i2c_q.ack <= 1'b0;
        end
    end

    assign command  = i2c_q.command;
    assign enable   = i2c_q.enable;
    assign ack      = i2c_q.ack;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_oled_cmd_seq.sv
// Directed bench for oled_cmd_seq: a per-cycle vector table for the user
// stream (ROM excluded build) plus transaction sequences that work in
// either build (OLED_INIT_ROM_EN selects the ROM expectations).
module tb_oled_cmd_seq;

    localparam int CNT_W = 8;
`ifdef OLED_INIT_ROM_EN
    localparam int NROM = 25;
    localparam logic [7:0] ROM_REF [0:24] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };
`else
    localparam int NROM = 0;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             next = 1'b0;
    logic             in_ready, enable, ack, busy, done;
    logic [7:0]       command;
    logic [CNT_W-1:0] sent_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    oled_cmd_seq #(.INIT_LEN(25), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .next     (next),
        .command  (command),
        .enable   (enable),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       st, vl;
        logic [7:0] d;
        logic       nx;
        logic [7:0] cmd;
        logic       en, ak, bz, dn, rd;
        int         cnt;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic st, logic vl, logic [7:0] d, logic nx,
                                logic [7:0] cmd, logic en, logic ak, logic bz,
                                logic dn, logic rd, int cnt);
        vec_t v;
        v.st = st; v.vl = vl; v.d = d; v.nx = nx;
        v.cmd = cmd; v.en = en; v.ak = ak; v.bz = bz; v.dn = dn; v.rd = rd; v.cnt = cnt;
        tv.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] cmd, input logic en,
                           input logic ak, input logic bz, input logic dn,
                           input logic rd, input int cnt);
        chk({nm, " command"},  command,  cmd);
        chk({nm, " enable"},   enable,   en);
        chk({nm, " ack"},      ack,      ak);
        chk({nm, " busy"},     busy,     bz);
        chk({nm, " done"},     done,     dn);
        chk({nm, " in_ready"}, in_ready, rd);
        chk({nm, " sent_cnt"}, sent_cnt, cnt);
    endtask

    function automatic logic [7:0] ubyte(int u);
        return 8'h40 + u[7:0];
    endfunction

    function automatic logic [7:0] expb(int k);
`ifdef OLED_INIT_ROM_EN
        if (k < NROM) return ROM_REF[k];
`endif
        return ubyte(k - NROM);
    endfunction

    function automatic int sat(int n);
        return (n > 255) ? 255 : n;
    endfunction

    // One full transaction: nuser user bytes after the ROM bytes. abort_at>0
    // pulls reset during the rising next that would fetch byte abort_at.
    task automatic run_tx(input int nuser, input string tag, input int abort_at);
        int total;
        int u;
        total = NROM + nuser;
        u = 0;
        @(negedge clock); start = 1'b1; next = 1'b0;
        in_valid = (nuser > 0); in_data = ubyte(0);
        #1 chk({tag, " idle busy"}, busy, 1'b0);
        @(negedge clock); start = 1'b0;
        #1 chk({tag, " load rdy"}, in_ready, (NROM == 0));
        chk({tag, " load en"}, enable, 1'b0);
        chk({tag, " load busy"}, busy, 1'b1);
        chk({tag, " load cnt"}, sent_cnt, 0);
        if (in_valid && in_ready) u++;
        @(negedge clock); in_valid = (u < nuser); in_data = ubyte(u);
        #1 chk({tag, " first cmd"}, command, expb(0));
        chk({tag, " first en"}, enable, 1'b1);
        chk({tag, " first cnt"}, sent_cnt, 1);
        if (in_valid && in_ready) u++;
        for (int k = 1; k <= total; k++) begin
            @(negedge clock); start = 1'b0; next = 1'b1;
            in_valid = (u < nuser); in_data = ubyte(u);
            if (k == abort_at) begin
                #1 reset_n = 1'b0;
                #1 chk_all({tag, " in reset"}, 8'h00, 0, 0, 0, 0, 0, 0);
                @(negedge clock);
                #1 chk({tag, " reset done"}, done, 1'b0);
                chk({tag, " reset busy"}, busy, 1'b0);
                reset_n = 1'b1; next = 1'b0; in_valid = 1'b0;
                return;
            end
            #1 chk($sformatf("%s rise%0d rdy", tag, k), in_ready, (k >= NROM));
            if (in_valid && in_ready) u++;
            if (k < total) begin
                @(negedge clock); next = 1'b0; in_valid = (u < nuser); in_data = ubyte(u);
                #1 chk($sformatf("%s b%0d cmd", tag, k), command, expb(k));
                chk($sformatf("%s b%0d ack", tag, k), ack, 1'b1);
                chk($sformatf("%s b%0d en", tag, k), enable, 1'b1);
                chk($sformatf("%s b%0d rdy", tag, k), in_ready, 1'b0);
                chk($sformatf("%s b%0d cnt", tag, k), sent_cnt, sat(k + 1));
                if (in_valid && in_ready) u++;
                @(negedge clock); start = (k == 2);
                #1 chk($sformatf("%s b%0d ackdrop", tag, k), ack, 1'b0);
                chk($sformatf("%s b%0d idle rdy", tag, k), in_ready, 1'b0);
                if (in_valid && in_ready) u++;
            end else begin
                @(negedge clock); next = 1'b0; in_valid = 1'b0;
                #1 chk({tag, " fin done"}, done, 1'b1);
                chk({tag, " fin en"}, enable, 1'b0);
                chk({tag, " fin cmd"}, command, expb(total - 1));
                chk({tag, " fin cnt"}, sent_cnt, sat(total));
                @(negedge clock);
                #1 chk({tag, " post done"}, done, 1'b0);
                chk({tag, " post busy"}, busy, 1'b0);
            end
        end
    endtask

    initial begin
        //   st vl data   nx  cmd   en ak bz dn rd cnt
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0);  // idle after reset
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0);  // start
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0);  // LOAD, nothing offered
        add(0, 1, 8'h11, 0, 8'h00, 0, 0, 1, 0, 1, 0);  // LOAD takes 0x11
        add(0, 1, 8'h22, 0, 8'h11, 1, 0, 1, 0, 0, 1);  // waiting, no request
        add(0, 1, 8'h22, 1, 8'h11, 1, 0, 1, 0, 1, 1);  // rise takes 0x22
        add(0, 0, 8'h00, 1, 8'h22, 1, 1, 1, 0, 0, 2);  // ACKED, next held
        add(0, 0, 8'h00, 0, 8'h22, 1, 1, 1, 0, 0, 2);  // next low, ack one more cycle
        add(0, 0, 8'h00, 0, 8'h22, 1, 0, 1, 0, 0, 2);
        add(0, 0, 8'h00, 1, 8'h22, 1, 0, 1, 0, 1, 2);  // rise, stream empty
        add(0, 0, 8'h00, 1, 8'h22, 0, 0, 1, 1, 0, 2);  // FINISH
        add(0, 0, 8'h00, 0, 8'h22, 0, 0, 0, 0, 0, 2);  // IDLE, command held
        add(1, 0, 8'h00, 0, 8'h22, 0, 0, 0, 0, 0, 2);  // start again
        add(0, 1, 8'h33, 0, 8'h22, 0, 0, 1, 0, 1, 0);  // LOAD clears count
        add(1, 1, 8'h44, 1, 8'h33, 1, 0, 1, 0, 1, 1);  // rise; start ignored
        for (int i = 0; i < 9; i++)                    // next held 9 more cycles
            add(i == 3, 1, 8'h55, 1, 8'h44, 1, 1, 1, 0, 0, 2);
        add(0, 1, 8'h55, 0, 8'h44, 1, 1, 1, 0, 0, 2);
        add(0, 1, 8'h55, 0, 8'h44, 1, 0, 1, 0, 0, 2);
        add(0, 1, 8'h55, 1, 8'h44, 1, 0, 1, 0, 1, 2);  // takes 0x55
        add(0, 0, 8'h00, 0, 8'h55, 1, 1, 1, 0, 0, 3);
        add(0, 0, 8'h00, 1, 8'h55, 1, 0, 1, 0, 1, 3);  // rise, empty
        add(0, 0, 8'h00, 0, 8'h55, 0, 0, 1, 1, 0, 3);  // FINISH
        add(0, 0, 8'h00, 0, 8'h55, 0, 0, 0, 0, 0, 3);

        repeat (2) @(negedge clock);
        #1 chk_all("reset", 8'h00, 0, 0, 0, 0, 0, 0);
        @(negedge clock); reset_n = 1'b1;

`ifndef OLED_INIT_ROM_EN
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clock);
            start = tv[i].st; in_valid = tv[i].vl; in_data = tv[i].d; next = tv[i].nx;
            #1 chk_all($sformatf("vec%0d", i), tv[i].cmd, tv[i].en, tv[i].ak,
                       tv[i].bz, tv[i].dn, tv[i].rd, tv[i].cnt);
        end
        start = 1'b0; in_valid = 1'b0; next = 1'b0;
        run_tx(2, "user2", 0);
`else
        run_tx(0, "rom", 0);
        run_tx(1, "rom+user", 0);
`endif
        run_tx(8, "abort", 5);
        run_tx(1, "restart", 0);
        run_tx(260, "sat", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
